// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the two-player board game sequencer: FSM states,
// winner encodings and the characters announced over the UART.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        WAIT_VALID = 3'd2,
        CHECK      = 3'd3,
        ANNOUNCE   = 3'd4,
        DONE       = 3'd5
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_A    = 2'd1;
    localparam logic [1:0] WIN_B    = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam logic [7:0] CHAR_A = 8'h41;
    localparam logic [7:0] CHAR_B = 8'h42;
    localparam logic [7:0] CHAR_D = 8'h44;

    function automatic logic [7:0] win_char(input logic [1:0] w);
        logic [7:0] c;
        case (w)
            WIN_A:    c = CHAR_A;
            WIN_B:    c = CHAR_B;
            WIN_DRAW: c = CHAR_D;
            default:  c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_sequencer_line_checker.sv
// Combinational detector: reports whether a board holds any complete row,
// column, or (square boards only) either complete diagonal.
module line_checker #(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic [ROWS*COLS-1:0] board_i,
    output logic                 win_o
);

    localparam int N = ROWS * COLS;
    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [N-1:0] ROW_MASK = N'({COLS{1'b1}});

    logic [N-1:0] mask_s;

    // Build each candidate line as a bit mask and test it against the board.
    always_comb begin
        win_o  = 1'b0;
        mask_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            mask_s = ROW_MASK << (r * COLS);
            win_o  = win_o | ((board_i & mask_s) == mask_s);
        end
        for (int c = 0; c < COLS; c++) begin
            mask_s = '0;
            for (int r = 0; r < ROWS; r++) begin
                mask_s = mask_s | (ONE << (r * COLS + c));
            end
            win_o = win_o | ((board_i & mask_s) == mask_s);
        end
        if (ROWS == COLS) begin
            mask_s = '0;
            for (int i = 0; i < ROWS; i++) begin
                mask_s = mask_s | (ONE << (i * COLS + i));
            end
            win_o  = win_o | ((board_i & mask_s) == mask_s);
            mask_s = '0;
            for (int i = 0; i < ROWS; i++) begin
                mask_s = mask_s | (ONE << (i * COLS + (COLS - 1 - i)));
            end
            win_o = win_o | ((board_i & mask_s) == mask_s);
        end else begin
            win_o = win_o;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: alternates moves between players through an external
// user-input block, detects win/draw/forfeit and announces the result on UART.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ui_req,
    output logic                 ui_target_a,
    output logic [ROWS*COLS-1:0] ui_board_a,
    output logic [ROWS*COLS-1:0] ui_board_b,
    input  logic                 ui_ready,
    input  logic                 ui_valid,
    input  logic                 ui_error,
    input  logic [ROWS*COLS-1:0] ui_board_a_out,
    input  logic [ROWS*COLS-1:0] ui_board_b_out,
    input  logic                 sub_uart_wr,
    input  logic [7:0]           sub_uart_d,
    output logic                 uart_wr,
    output logic [7:0]           uart_d,
    input  logic                 uart_ready,
    output logic                 busy,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic [ROWS*COLS-1:0] board_a,
    output logic [ROWS*COLS-1:0] board_b,
    output logic [3:0]           retry_cnt
);

    localparam int N = ROWS * COLS;
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_e       state_q, state_d;
    logic [N-1:0] board_a_q, board_a_d, board_b_q, board_b_d;
    logic [3:0]   retry_q, retry_d, retry_inc_s;
    logic [1:0]   winner_q, winner_d;
    logic         target_a_q, target_a_d;
    logic         game_over_q, game_over_d;
    logic         busy_q, busy_d;
    logic         own_wr_s, win_s;
    logic [7:0]   own_d_s;

    line_checker #(.ROWS(ROWS), .COLS(COLS)) u_line_checker (
        .board_i (target_a_q ? board_a_q : board_b_q),
        .win_o   (win_s)
    );

    assign retry_inc_s = (retry_q == RETRY_LIMIT) ? retry_q : retry_q + 4'd1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            board_a_q   <= '0;
            board_b_q   <= '0;
            retry_q     <= 4'd0;
            winner_q    <= WIN_NONE;
            target_a_q  <= 1'b1;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_a_q   <= board_a_d;
            board_b_q   <= board_b_d;
            retry_q     <= retry_d;
            winner_q    <= winner_d;
            target_a_q  <= target_a_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic plus the single-cycle ui_req / own UART strobes.
    always_comb begin
        state_d     = state_q;
        board_a_d   = board_a_q;
        board_b_d   = board_b_q;
        retry_d     = retry_q;
        winner_d    = winner_q;
        target_a_d  = target_a_q;
        game_over_d = game_over_q;
        busy_d      = busy_q;
        ui_req      = 1'b0;
        own_wr_s    = 1'b0;
        own_d_s     = 8'h00;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    board_a_d   = '0;
                    board_b_d   = '0;
                    retry_d     = 4'd0;
                    winner_d    = WIN_NONE;
                    target_a_d  = 1'b1;
                    game_over_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = WAIT_READY;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_READY: begin
                if (ui_ready) begin
                    ui_req  = 1'b1;
                    state_d = WAIT_VALID;
                end else begin
                    state_d = WAIT_READY;
                end
            end
            WAIT_VALID: begin
                if (ui_valid && ui_error) begin
                    retry_d = retry_inc_s;
                    if (retry_inc_s == RETRY_LIMIT) begin
                        winner_d = target_a_q ? WIN_B : WIN_A;
                        state_d  = ANNOUNCE;
                    end else begin
                        state_d = WAIT_READY;
                    end
                end else if (ui_valid) begin
                    board_a_d = ui_board_a_out;
                    board_b_d = ui_board_b_out;
                    retry_d   = 4'd0;
                    state_d   = CHECK;
                end else begin
                    state_d = WAIT_VALID;
                end
            end
            CHECK: begin
                // A completed line beats a full board.
                if (win_s) begin
                    winner_d = target_a_q ? WIN_A : WIN_B;
                    state_d  = ANNOUNCE;
                end else if (&(board_a_q | board_b_q)) begin
                    winner_d = WIN_DRAW;
                    state_d  = ANNOUNCE;
                end else begin
                    target_a_d = ~target_a_q;
                    state_d    = WAIT_READY;
                end
            end
            ANNOUNCE: begin
                own_d_s = win_char(winner_q);
                if (uart_ready) begin
                    own_wr_s    = 1'b1;
                    busy_d      = 1'b0;
                    game_over_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = ANNOUNCE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign uart_wr     = (state_q == ANNOUNCE) ? own_wr_s : sub_uart_wr;
    assign uart_d      = (state_q == ANNOUNCE) ? own_d_s  : sub_uart_d;
    assign ui_target_a = target_a_q;
    assign ui_board_a  = board_a_q;
    assign ui_board_b  = board_b_q;
    assign board_a     = board_a_q;
    assign board_b     = board_b_q;
    assign busy        = busy_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer on a 3x3 board.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ui_req, ui_target_a;
    logic [8:0] ui_board_a, ui_board_b;
    logic       ui_ready = 1'b0, ui_valid = 1'b0, ui_error = 1'b0;
    logic [8:0] ui_board_a_out = 9'd0, ui_board_b_out = 9'd0;
    logic       sub_uart_wr = 1'b0;
    logic [7:0] sub_uart_d = 8'h00;
    logic       uart_wr;
    logic [7:0] uart_d;
    logic       uart_ready = 1'b0;
    logic       busy, game_over;
    logic [1:0] winner;
    logic [8:0] board_a, board_b;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int ann_cnt = 0;
    int ann_base = 0;
    logic [8:0] ba, bb;
    logic       tgt;

    game_sequencer #(.ROWS(3), .COLS(3), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ui_req(ui_req), .ui_target_a(ui_target_a),
        .ui_board_a(ui_board_a), .ui_board_b(ui_board_b),
        .ui_ready(ui_ready), .ui_valid(ui_valid), .ui_error(ui_error),
        .ui_board_a_out(ui_board_a_out), .ui_board_b_out(ui_board_b_out),
        .sub_uart_wr(sub_uart_wr), .sub_uart_d(sub_uart_d),
        .uart_wr(uart_wr), .uart_d(uart_d), .uart_ready(uart_ready),
        .busy(busy), .game_over(game_over), .winner(winner),
        .board_a(board_a), .board_b(board_b), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Count characters the sequencer itself puts on the UART.
    always @(posedge clk) begin
        if (reset && uart_wr && !sub_uart_wr) ann_cnt <= ann_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start_game();
        ann_base = ann_cnt;
        ba = 9'd0; bb = 9'd0; tgt = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_over", game_over, 0);
        check_eq("start_winner", winner, 0);
        check_eq("start_board_a", board_a, 0);
        check_eq("start_target", ui_target_a, 1);
    endtask

    task automatic move(input int r, input int c, input logic [1:0] exp_w, input bit poke);
        int idx = r * 3 + c;
        if (tgt) ba[idx] = 1'b1; else bb[idx] = 1'b1;
        ui_ready = 1'b1; #1;
        check_eq("ui_req_hi", ui_req, 1);
        @(posedge clk); #1;
        ui_ready = 1'b0;
        check_eq("ui_req_lo", ui_req, 0);
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("poke_busy", busy, 1);
            check_eq("poke_board_a", board_a, {23'd0, ba} & ~(32'd1 << idx) & {23'd0, {9{tgt}}}
                     | ({23'd0, ba} & {23'd0, {9{~tgt}}}));
        end
        ui_valid = 1'b1; ui_error = 1'b0;
        ui_board_a_out = ba; ui_board_b_out = bb;
        @(posedge clk); #1;
        ui_valid = 1'b0;
        check_eq("board_a", board_a, ba);
        check_eq("ui_board_b", ui_board_b, bb);
        check_eq("retry_zero", retry_cnt, 0);
        @(posedge clk); #1;
        check_eq("winner", winner, exp_w);
        if (exp_w == 2'd0) begin
            tgt = ~tgt;
            check_eq("target", ui_target_a, tgt);
        end
    endtask

    task automatic err_move(input logic [3:0] exp_retry, input logic [1:0] exp_w);
        ui_ready = 1'b1;
        @(posedge clk); #1;
        ui_ready = 1'b0;
        ui_valid = 1'b1; ui_error = 1'b1;
        ui_board_a_out = 9'h1FF; ui_board_b_out = 9'h1FF;
        @(posedge clk); #1;
        ui_valid = 1'b0; ui_error = 1'b0;
        check_eq("err_retry", retry_cnt, exp_retry);
        check_eq("err_target", ui_target_a, tgt);
        check_eq("err_board_a", board_a, ba);
        check_eq("err_winner", winner, exp_w);
    endtask

    task automatic announce(input logic [7:0] exp_char);
        check_eq("ann_wait_wr", uart_wr, 0);
        check_eq("ann_char", uart_d, exp_char);
        uart_ready = 1'b1; #1;
        check_eq("ann_wr", uart_wr, 1);
        @(posedge clk); #1;
        uart_ready = 1'b0;
        check_eq("done_over", game_over, 1);
        check_eq("done_busy", busy, 0);
        check_eq("ann_count", ann_cnt - ann_base, 1);
        @(posedge clk); #1;
        check_eq("done_hold_wr", uart_wr, 0);
        check_eq("done_hold_board", board_a, ba);
    endtask

    task automatic check_reset_values();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_over", game_over, 0);
        check_eq("rst_winner", winner, 0);
        check_eq("rst_target", ui_target_a, 1);
        check_eq("rst_board_a", board_a, 0);
        check_eq("rst_board_b", board_b, 0);
        check_eq("rst_retry", retry_cnt, 0);
        check_eq("rst_ui_req", ui_req, 0);
        check_eq("rst_uart_wr", uart_wr, 0);
        check_eq("rst_uart_d", uart_d, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b1;
        @(posedge clk); #1;

        // A wins on the top row; also UART pass-through and ignored start.
        start_game();
        move(0, 0, 2'd0, 1'b0);
        sub_uart_wr = 1'b1; sub_uart_d = 8'h3F; #1;
        check_eq("pass_wr", uart_wr, 1);
        check_eq("pass_d", uart_d, 8'h3F);
        sub_uart_wr = 1'b0; sub_uart_d = 8'h00;
        move(1, 0, 2'd0, 1'b1);
        move(0, 1, 2'd0, 1'b0);
        move(1, 1, 2'd0, 1'b0);
        move(0, 2, 2'd1, 1'b0);
        announce(8'h41);

        // Full board without a line.
        start_game();
        move(0, 0, 2'd0, 1'b0);
        move(0, 1, 2'd0, 1'b0);
        move(0, 2, 2'd0, 1'b0);
        move(1, 1, 2'd0, 1'b0);
        move(1, 0, 2'd0, 1'b0);
        move(1, 2, 2'd0, 1'b0);
        move(2, 1, 2'd0, 1'b0);
        move(2, 0, 2'd0, 1'b0);
        move(2, 2, 2'd3, 1'b0);
        announce(8'h44);

        // A forfeits after three consecutive invalid inputs.
        start_game();
        err_move(4'd1, 2'd0);
        err_move(4'd2, 2'd0);
        err_move(4'd3, 2'd2);
        announce(8'h42);

        // Error then valid move, ignored ui_valid, then reset mid-move.
        start_game();
        err_move(4'd1, 2'd0);
        move(0, 0, 2'd0, 1'b0);
        ui_valid = 1'b1; ui_board_a_out = 9'h1FF; ui_board_b_out = 9'h1FF;
        @(posedge clk); #1;
        ui_valid = 1'b0;
        check_eq("stray_valid_board", board_a, ba);
        check_eq("stray_valid_retry", retry_cnt, 0);
        ui_ready = 1'b1;
        @(posedge clk); #1;
        ui_ready = 1'b0;
        reset = 1'b0; #1;
        check_reset_values();
        @(posedge clk); #1;
        check_reset_values();
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_no_char", ann_cnt - ann_base, 0);

        // Clean game after the abandoned one.
        start_game();
        move(0, 0, 2'd0, 1'b0);
        move(1, 0, 2'd0, 1'b0);
        move(0, 1, 2'd0, 1'b0);
        move(1, 1, 2'd0, 1'b0);
        move(0, 2, 2'd1, 1'b0);
        announce(8'h41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
